rf_wb_scheduler: RTL and testbench
==================================

RF_WB_SCHEDULER -- requirements
Module: rf_wb_scheduler

Interface
REQ-001 SHALL have parameter DW, default 32, meaning register data width.
REQ-002 SHALL have parameter AW, default 5, meaning register address width (2^AW registers).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have ports alu_valid, alu_rdst, alu_data, meaning the ALU writeback request: input, input, input; widths 1, AW, DW.
REQ-006 SHALL have port alu_ready, output, 1, meaning the ALU request is accepted this cycle.
REQ-007 SHALL have ports mem_valid, mem_rdst, mem_data, meaning the memory-load writeback request: input, input, input; widths 1, AW, DW.
REQ-008 SHALL have port mem_ready, output, 1, meaning the memory request is accepted this cycle.
REQ-009 SHALL have ports Rdst, RY and RF_WRITE, output, with widths AW, DW and 1, meaning they drive the register-file write port.
REQ-010 SHALL have ports issue_valid, issue_rdst, input, widths 1, AW, meaning an instruction issued that will write issue_rdst.
REQ-011 SHALL have ports Rsrc1, Rsrc2, input, AW each, meaning the source registers of the instruction in decode.
REQ-012 SHALL have port stall, output, 1, meaning a RAW hazard exists on Rsrc1 or Rsrc2.

Function
REQ-013 SHALL accept at most one request per cycle: a transfer occurs when valid && ready.
REQ-014 SHALL derive ready combinationally from the current valids and the arbitration state; ready SHALL NOT depend on RF_WRITE.
REQ-015 SHALL present an accepted request on Rdst and RY with RF_WRITE=1 exactly one cycle after acceptance (registered outputs, latency 1).
REQ-016 SHALL hold RF_WRITE=0 in any cycle following a cycle with no acceptance; Rdst and RY SHALL hold their last values.
REQ-017 SHALL, with a single valid requester, grant it in the same cycle.
REQ-018 SHALL drop accepted writes to register 0: ready is asserted and the scoreboard is updated, but RF_WRITE stays 0 in the following cycle.
REQ-019 SHALL keep a scoreboard of 2^AW pending bits; issue_valid sets pending[issue_rdst]; an accepted write clears pending[rdst].
REQ-020 SHALL, when a set and a clear target the same register in one cycle, leave the bit set (the newer producer wins).
REQ-021 SHALL ignore issue_valid with issue_rdst=0; pending[0] SHALL always read 0.
REQ-022 SHALL drive stall combinationally as pending[Rsrc1] OR pending[Rsrc2], using the registered scoreboard (no same-cycle bypass).
REQ-023 SHALL NOT stall on a register whose pending bit clears in the current cycle until the next cycle.

Reset
REQ-024 SHALL, while rst_n=0, force RF_WRITE=0, Rdst=0, RY=0, all pending bits 0, stall=0 and the arbitration pointer to ALU-next.
REQ-025 SHALL take effect immediately on rst_n falling, including mid-transfer; a request accepted in the cycle reset asserts SHALL be lost.
REQ-026 SHALL require both requesters to re-present after rst_n rises; the first posedge after release SHALL be able to accept.

Configuration
REQ-027 SHALL implement macro RF_WB_RR_ARB_EN; when defined, contention SHALL be resolved round-robin, with the pointer toggling to the other requester after each contended grant.
REQ-028 SHALL, without RF_WB_RR_ARB_EN, use fixed priority, with mem always winning contention and the alu waiting.

Verification
REQ-029 SHALL cover this scenario: alu_valid=1, rdst=3, data=0xDEADBEEF, alone -> alu_ready=1 same cycle; next cycle RF_WRITE=1, Rdst=3, RY=0xDEADBEEF.
REQ-030 SHALL cover this scenario: both valid for 4 cycles (alu rdst=1, mem rdst=2) with RR enabled -> grants alu,mem,alu,mem; with RR disabled -> mem on all 4 cycles and alu_ready=0.
REQ-031 SHALL cover this scenario: issue_valid with rdst=5, then Rsrc1=5 -> stall=1 next cycle; accept write rdst=5 -> stall=0 one cycle after acceptance.
REQ-032 SHALL cover this scenario: same-cycle issue rdst=7 and accepted write rdst=7 -> pending[7] remains 1 and stall=1 for Rsrc2=7.
REQ-033 SHALL cover this scenario: accepted write rdst=0 with data=0x12345678 -> ready=1 and RF_WRITE=0 next cycle; issue rdst=0 with Rsrc1=0 -> stall=0.
REQ-034 SHALL cover this scenario: rst_n pulled low between clock edges with pending[9]=1 and RF_WRITE=1 -> all outputs and pending bits 0 immediately, before the next posedge.

Source files
------------

// File: rtl/rf_wb_scheduler.sv
// Register-file writeback arbiter (ALU vs memory load) with a RAW-hazard scoreboard.
// Latency: 1 cycle from acceptance to RF_WRITE/Rdst/RY. Backpressure: the losing requester sees ready=0 and holds its request.
// Optional RF_WB_RR_ARB_EN: round-robin on contention; without it, mem has fixed priority.
module rf_wb_scheduler #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alu_valid,
    input  logic [AW-1:0] alu_rdst,
    input  logic [DW-1:0] alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  logic [AW-1:0] mem_rdst,
    input  logic [DW-1:0] mem_data,
    output logic          mem_ready,
    output logic [AW-1:0] Rdst,
    output logic [DW-1:0] RY,
    output logic          RF_WRITE,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_rdst,
    input  logic [AW-1:0] Rsrc1,
    input  logic [AW-1:0] Rsrc2,
    output logic          stall
);
    localparam int NREG = 1 << AW;

    logic            gnt_alu;
    logic            gnt_mem;
    logic            acc;
    logic [AW-1:0]   wr_rdst;
    logic [DW-1:0]   wr_data;
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;

`ifdef RF_WB_RR_ARB_EN
    // ptr_mem=1 means mem wins the next contended cycle; reset leaves ALU next.
    logic ptr_mem;

    always_comb begin
        gnt_alu = alu_valid & (~mem_valid | ~ptr_mem);
        gnt_mem = mem_valid & (~alu_valid | ptr_mem);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_mem <= 1'b0;
        end else if (alu_valid && mem_valid) begin
            ptr_mem <= ~ptr_mem;
        end
    end
`else
    always_comb begin
        gnt_mem = mem_valid;
        gnt_alu = alu_valid & ~mem_valid;
    end
`endif

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;
    assign acc       = gnt_alu | gnt_mem;
    assign wr_rdst   = gnt_mem ? mem_rdst : alu_rdst;
    assign wr_data   = gnt_mem ? mem_data : alu_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RF_WRITE <= 1'b0;
            Rdst     <= '0;
            RY       <= '0;
        end else begin
            RF_WRITE <= acc && (wr_rdst != '0);
            if (acc) begin
                Rdst <= wr_rdst;
                RY   <= wr_data;
            end
        end
    end

    // Set is applied after clear so a newer producer to the same register wins.
    always_comb begin
        pending_nxt = pending;
        if (acc) begin
            pending_nxt[wr_rdst] = 1'b0;
        end
        if (issue_valid) begin
            pending_nxt[issue_rdst] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    assign stall = pending[Rsrc1] | pending[Rsrc2];

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed and randomized bench for rf_wb_scheduler against a simple transaction-level model.
module tb_rf_wb_scheduler;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_rdst = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_rdst = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic [AW-1:0] Rdst;
    logic [DW-1:0] RY;
    logic          RF_WRITE;
    logic          issue_valid = 1'b0;
    logic [AW-1:0] issue_rdst = '0;
    logic [AW-1:0] Rsrc1 = '0;
    logic [AW-1:0] Rsrc2 = '0;
    logic          stall;

    int tests = 0;
    int fails = 0;

    // Reference model state
    bit            m_pend [32];
    bit            m_wr;
    bit [AW-1:0]   m_rdst;
    bit [DW-1:0]   m_ry;
    int            m_next_winner;   // 0 = ALU takes next contended cycle, 1 = mem

    rf_wb_scheduler #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rdst(alu_rdst), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rdst(mem_rdst), .mem_data(mem_data), .mem_ready(mem_ready),
        .Rdst(Rdst), .RY(RY), .RF_WRITE(RF_WRITE),
        .issue_valid(issue_valid), .issue_rdst(issue_rdst),
        .Rsrc1(Rsrc1), .Rsrc2(Rsrc2), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        m_wr = 1'b0;
        m_rdst = '0;
        m_ry = '0;
        m_next_winner = 0;
    endtask

    // Who the model expects to win: 0 none, 1 alu, 2 mem
    function automatic int model_winner();
        if (alu_valid && !mem_valid) return 1;
        if (mem_valid && !alu_valid) return 2;
        if (!alu_valid && !mem_valid) return 0;
`ifdef RF_WB_RR_ARB_EN
        return (m_next_winner == 0) ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic step(input string tag);
        int w;
        bit [AW-1:0] rd;
        bit [DW-1:0] dat;
        #1;
        w = model_winner();
        chk({tag, ".alu_ready"}, 32'(alu_ready), 32'(w == 1));
        chk({tag, ".mem_ready"}, 32'(mem_ready), 32'(w == 2));
        chk({tag, ".stall"}, 32'(stall), 32'(m_pend[Rsrc1] | m_pend[Rsrc2]));
        @(posedge clk);
        if (alu_valid && mem_valid) m_next_winner = 1 - m_next_winner;
        m_wr = 1'b0;
        if (w != 0) begin
            rd  = (w == 1) ? alu_rdst : mem_rdst;
            dat = (w == 1) ? alu_data : mem_data;
            m_wr = (rd != 0);
            m_rdst = rd;
            m_ry = dat;
            m_pend[rd] = 1'b0;
        end
        if (issue_valid && issue_rdst != 0) m_pend[issue_rdst] = 1'b1;
        #1;
        chk({tag, ".RF_WRITE"}, 32'(RF_WRITE), 32'(m_wr));
        chk({tag, ".Rdst"}, 32'(Rdst), 32'(m_rdst));
        chk({tag, ".RY"}, RY, m_ry);
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        mem_valid = 1'b0;
        issue_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        // Reset state
        #12;
        chk("rst.RF_WRITE", 32'(RF_WRITE), 32'd0);
        chk("rst.Rdst", 32'(Rdst), 32'd0);
        chk("rst.RY", RY, 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single ALU requester
        alu_valid = 1'b1; alu_rdst = 5'd3; alu_data = 32'hDEADBEEF;
        #1 chk("alu_alone.ready", 32'(alu_ready), 32'd1);
        step("alu_alone");
        chk("alu_alone.wr", 32'(RF_WRITE), 32'd1);
        chk("alu_alone.rdst", 32'(Rdst), 32'd3);
        chk("alu_alone.ry", RY, 32'hDEADBEEF);
        idle();
        step("idle");
        chk("idle.wr_low", 32'(RF_WRITE), 32'd0);
        chk("idle.ry_hold", RY, 32'hDEADBEEF);

        // Contention for four cycles
        alu_valid = 1'b1; alu_rdst = 5'd1; alu_data = 32'hA1A1A1A1;
        mem_valid = 1'b1; mem_rdst = 5'd2; mem_data = 32'hB2B2B2B2;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef RF_WB_RR_ARB_EN
            chk("contend.alu_ready", 32'(alu_ready), 32'((i % 2) == 0));
            chk("contend.mem_ready", 32'(mem_ready), 32'((i % 2) == 1));
`else
            chk("contend.alu_ready", 32'(alu_ready), 32'd0);
            chk("contend.mem_ready", 32'(mem_ready), 32'd1);
`endif
            step("contend");
        end
        idle();
        step("idle2");

        // RAW hazard set then cleared
        issue_valid = 1'b1; issue_rdst = 5'd5;
        step("issue5");
        issue_valid = 1'b0; Rsrc1 = 5'd5;
        #1 chk("raw5.stall_set", 32'(stall), 32'd1);
        alu_valid = 1'b1; alu_rdst = 5'd5; alu_data = 32'h55;
        #1 chk("raw5.stall_during_accept", 32'(stall), 32'd1);
        step("wr5");
        idle();
        #1 chk("raw5.stall_clear", 32'(stall), 32'd0);
        Rsrc1 = 5'd0;

        // Same-cycle set and clear on register 7
        issue_valid = 1'b1; issue_rdst = 5'd7;
        step("issue7");
        alu_valid = 1'b1; alu_rdst = 5'd7; alu_data = 32'h77;
        step("set_clear7");
        idle();
        Rsrc2 = 5'd7;
        #1 chk("set_wins7.stall", 32'(stall), 32'd1);
        mem_valid = 1'b1; mem_rdst = 5'd7; mem_data = 32'h70;
        step("clear7");
        idle();
        Rsrc2 = 5'd0;

        // Writes and issues to register 0
        mem_valid = 1'b1; mem_rdst = 5'd0; mem_data = 32'h12345678;
        #1 chk("r0.mem_ready", 32'(mem_ready), 32'd1);
        step("r0_write");
        chk("r0.no_write", 32'(RF_WRITE), 32'd0);
        idle();
        issue_valid = 1'b1; issue_rdst = 5'd0;
        step("r0_issue");
        issue_valid = 1'b0; Rsrc1 = 5'd0;
        #1 chk("r0.stall", 32'(stall), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            alu_valid   = 1'($urandom);
            mem_valid   = 1'($urandom);
            issue_valid = 1'($urandom);
            alu_rdst    = AW'($urandom_range(0, 7));
            mem_rdst    = AW'($urandom_range(0, 7));
            issue_rdst  = AW'($urandom_range(0, 7));
            alu_data    = $urandom;
            mem_data    = $urandom;
            Rsrc1       = AW'($urandom_range(0, 7));
            Rsrc2       = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            step("rand");
        end
        idle();

        // Asynchronous reset mid-cycle with a pending bit and an active write
        issue_valid = 1'b1; issue_rdst = 5'd9;
        alu_valid = 1'b1; alu_rdst = 5'd4; alu_data = 32'hCAFEF00D;
        step("pre_reset");
        issue_valid = 1'b0; Rsrc1 = 5'd9;
        #1 chk("pre_reset.stall", 32'(stall), 32'd1);
        chk("pre_reset.wr", 32'(RF_WRITE), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst.wr", 32'(RF_WRITE), 32'd0);
        chk("async_rst.rdst", 32'(Rdst), 32'd0);
        chk("async_rst.ry", RY, 32'd0);
        chk("async_rst.stall", 32'(stall), 32'd0);
        model_reset();
        @(posedge clk);
        #1 chk("in_rst.wr", 32'(RF_WRITE), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alu_valid = 1'b1; alu_rdst = 5'd6; alu_data = 32'h600D600D;
        step("post_reset");
        chk("post_reset.wr", 32'(RF_WRITE), 32'd1);
        chk("post_reset.ry", RY, 32'h600D600D);
        chk("post_reset.pend9_clear", 32'(stall), 32'd0);
        idle();
        step("final");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
